// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round_ctrl
//  Description : Phase sequencer for a SHA-256 compression datapath. Accepts
//                16 streamed message words, then runs schedule expansion,
//                working-register init, 64 rounds and the H update, with a
//                start/busy/done handshake toward the host.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_round_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       first,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       w_we,
    output logic [5:0] w_addr,
    output logic       exp_en,
    output logic [5:0] exp_idx,
    output logic       init_en,
    output logic       h_iv_sel,
    output logic       rnd_en,
    output logic [5:0] rnd_idx,
    output logic       final_en,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    // Encoding is visible on the debug port, so values are pinned.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_INIT   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_FINAL  = 3'd5,
        ST_DONE   = 3'd6,
        ST_UNUSED = 3'd7
    } state_t;

    // Terminal counter values; the shared counter never wraps inside a phase.
    localparam logic [5:0] C_CNT_ZERO   = 6'd0;
    localparam logic [5:0] C_LOAD_LAST  = 6'd15;
    localparam logic [5:0] C_EXP_FIRST  = 6'd16;
    localparam logic [5:0] C_PHASE_LAST = 6'd63;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_cnt;
    logic [5:0] w_next_cnt;
    logic       r_iv_sel;
    logic       w_next_iv_sel;
    logic       w_load_accept;

    // A word is taken whenever the datapath offers one while we are loading.
    assign w_load_accept = (r_state == ST_LOAD) && msg_valid;

    // State, shared counter and latched FIRST; reset abandons any phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= C_CNT_ZERO;
            r_iv_sel <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_iv_sel <= w_next_iv_sel;
        end
    end

    // Next-state and counter sequencing through the fixed phase order.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_iv_sel = r_iv_sel;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_iv_sel = first;
                    w_next_cnt    = C_CNT_ZERO;
                    w_next_state  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Stall cycles (no valid word) hold the counter.
                if (w_load_accept) begin
                    if (r_cnt == C_LOAD_LAST) begin
                        w_next_cnt   = C_EXP_FIRST;
                        w_next_state = ST_EXPAND;
                    end else begin
                        w_next_cnt = r_cnt + 6'd1;
                    end
                end
            end
            ST_EXPAND: begin
                if (r_cnt == C_PHASE_LAST) begin
                    w_next_cnt   = C_CNT_ZERO;
                    w_next_state = ST_INIT;
                end else begin
                    w_next_cnt = r_cnt + 6'd1;
                end
            end
            ST_INIT: begin
                // Counter already 0 on entry, ready to serve as round index.
                w_next_cnt   = C_CNT_ZERO;
                w_next_state = ST_ROUND;
            end
            ST_ROUND: begin
                if (r_cnt == C_PHASE_LAST) begin
                    w_next_cnt   = C_CNT_ZERO;
                    w_next_state = ST_FINAL;
                end else begin
                    w_next_cnt = r_cnt + 6'd1;
                end
            end
            ST_FINAL: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                // START is deliberately not looked at here.
                w_next_state = ST_IDLE;
            end
            default: begin
                // Unreachable encoding recovers to IDLE.
                w_next_cnt   = C_CNT_ZERO;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; only the LOAD write strobe follows msg_valid.
    always_comb begin
        msg_ready = 1'b0;
        w_we      = 1'b0;
        w_addr    = 6'd0;
        exp_en    = 1'b0;
        exp_idx   = 6'd0;
        init_en   = 1'b0;
        rnd_en    = 1'b0;
        rnd_idx   = 6'd0;
        final_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                msg_ready = 1'b1;
                busy      = 1'b1;
                if (w_load_accept) begin
                    w_we   = 1'b1;
                    w_addr = r_cnt;
                end
            end
            ST_EXPAND: begin
                busy    = 1'b1;
                exp_en  = 1'b1;
                exp_idx = r_cnt;
                w_we    = 1'b1;
                w_addr  = r_cnt;
            end
            ST_INIT: begin
                busy    = 1'b1;
                init_en = 1'b1;
            end
            ST_ROUND: begin
                busy    = 1'b1;
                rnd_en  = 1'b1;
                rnd_idx = r_cnt;
            end
            ST_FINAL: begin
                busy     = 1'b1;
                final_en = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign h_iv_sel = r_iv_sel;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_round_ctrl
//  Description : Randomized bench for sha256_round_ctrl. Each block is turned
//                into an expected per-cycle output schedule built from the
//                phase lengths (16 words plus stalls, 48 expand, 1 init,
//                64 rounds, 1 final, 1 done) and compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       first = 1'b0;
    logic       msg_valid = 1'b0;
    logic       msg_ready, w_we, exp_en, init_en, h_iv_sel, rnd_en, final_en, busy, done;
    logic [5:0] w_addr, exp_idx, rnd_idx;
    logic [2:0] state;

    sha256_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first(first),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .w_we(w_we), .w_addr(w_addr),
        .exp_en(exp_en), .exp_idx(exp_idx), .init_en(init_en), .h_iv_sel(h_iv_sel),
        .rnd_en(rnd_en), .rnd_idx(rnd_idx), .final_en(final_en), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Strobe bundle bit positions: {ready, we, exp, init, rnd, final, busy, done}
    localparam logic [7:0] B_RDY  = 8'h80;
    localparam logic [7:0] B_WE   = 8'h40;
    localparam logic [7:0] B_EXP  = 8'h20;
    localparam logic [7:0] B_INIT = 8'h10;
    localparam logic [7:0] B_RND  = 8'h08;
    localparam logic [7:0] B_FIN  = 8'h04;
    localparam logic [7:0] B_BUSY = 8'h02;
    localparam logic [7:0] B_DONE = 8'h01;

    typedef struct {
        logic [2:0] st;
        bit         vin;
        bit         sin;
        logic [7:0] strb;
        logic [5:0] wa;
        logic [5:0] ea;
        logic [5:0] ra;
        bit         iv;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    bit model_iv = 1'b0;
    int stall_plan [16];
    int last_e0;
    int last_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input bit vin, input bit sin,
                                input logic [7:0] strb, input logic [5:0] wa,
                                input logic [5:0] ea, input logic [5:0] ra, input bit iv);
        exp_t x;
        x.st = st; x.vin = vin; x.sin = sin; x.strb = strb;
        x.wa = wa; x.ea = ea; x.ra = ra; x.iv = iv;
        return x;
    endfunction

    function automatic bit noise_bit(input bit noise, input bit quiet_val);
        if (noise) return 1'($urandom_range(0, 1));
        return quiet_val;
    endfunction

    function automatic logic [7:0] strobes();
        return {msg_ready, w_we, exp_en, init_en, rnd_en, final_en, busy, done};
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_strb"}, 32'(strobes()), 32'd0);
        check_val({tag, "_idx"}, 32'({w_addr, exp_idx, rnd_idx}), 32'd0);
        check_val({tag, "_iv"}, 32'(h_iv_sel), 32'd0);
        check_val({tag, "_state"}, 32'(state), 32'd0);
    endtask

    // Runs one block. noise drives random START/MSG_VALID where they must be
    // ignored; abort_mid pulls reset while RND_IDX is 20.
    task automatic run_block(input bit fv, input bit noise, input bit abort_mid);
        exp_t       sched[$];
        logic [5:0] wq[$];
        int         stall_total = 0;
        int         abort_j = -1;
        int         e0 = -1;
        int         done_edge = -1;
        int         bad_order = 0;

        sched.push_back(mk(3'd0, noise_bit(noise, 1'b1), 1'b1, 8'h00, 6'd0, 6'd0, 6'd0, model_iv));
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < stall_plan[k]; s++) begin
                sched.push_back(mk(3'd1, 1'b0, noise_bit(noise, 1'b0), B_RDY | B_BUSY,
                                   6'd0, 6'd0, 6'd0, fv));
                stall_total++;
            end
            sched.push_back(mk(3'd1, 1'b1, noise_bit(noise, 1'b0), B_RDY | B_WE | B_BUSY,
                               6'(k), 6'd0, 6'd0, fv));
        end
        for (int i = 16; i < 64; i++)
            sched.push_back(mk(3'd2, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0),
                               B_WE | B_EXP | B_BUSY, 6'(i), 6'(i), 6'd0, fv));
        sched.push_back(mk(3'd3, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0),
                           B_INIT | B_BUSY, 6'd0, 6'd0, 6'd0, fv));
        for (int t = 0; t < 64; t++) begin
            if (t == 20) abort_j = sched.size();
            sched.push_back(mk(3'd4, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0),
                               B_RND | B_BUSY, 6'd0, 6'd0, 6'(t), fv));
        end
        sched.push_back(mk(3'd5, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0),
                           B_FIN | B_BUSY, 6'd0, 6'd0, 6'd0, fv));
        sched.push_back(mk(3'd6, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0),
                           B_DONE, 6'd0, 6'd0, 6'd0, fv));

        for (int j = 0; j < sched.size(); j++) begin
            @(negedge clk);
            start     = sched[j].sin;
            first     = (j == 0) ? fv : 1'($urandom_range(0, 1));
            msg_valid = sched[j].vin;
            #1;
            check_val("state",   32'(state),    32'(sched[j].st));
            check_val("strobes", 32'(strobes()), 32'(sched[j].strb));
            check_val("w_addr",  32'(w_addr),   32'(sched[j].wa));
            check_val("exp_idx", 32'(exp_idx),  32'(sched[j].ea));
            check_val("rnd_idx", 32'(rnd_idx),  32'(sched[j].ra));
            check_val("h_iv_sel", 32'(h_iv_sel), 32'(sched[j].iv));
            check_val("excl_en", 32'($countones({exp_en, init_en, rnd_en, final_en}) > 1), 32'd0);
            check_val("we_scope", 32'(w_we && !(state == 3'd1 || state == 3'd2)), 32'd0);
            check_val("state_legal", 32'(state == 3'd7), 32'd0);
            if (j == 0) e0 = edge_cnt + 1;
            if (done && done_edge < 0) done_edge = edge_cnt;
            if (w_we && state == 3'd1) wq.push_back(w_addr);
            if (abort_mid && j == abort_j) begin
                #2;
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_all_zero("mid_reset");
                model_iv = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        start     = 1'b0;
        model_iv  = fv;
        // DONE rises 130 edges after the START edge plus one per stall.
        check_val("done_edge", 32'(done_edge - e0), 32'(130 + stall_total));
        check_val("load_count", 32'(wq.size()), 32'd16);
        foreach (wq[n]) if (wq[n] != 6'(n)) bad_order++;
        check_val("load_order", 32'(bad_order), 32'd0);
        last_e0   = e0;
        last_done = done_edge;
    endtask

    initial begin
        int chain_e0;
        rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal block, MSG_VALID constant high.
        foreach (stall_plan[k]) stall_plan[k] = 0;
        run_block(1'b1, 1'b0, 1'b0);

        // Stalled load: 3 stalls at word 5, 2 at word 15.
        stall_plan[5]  = 3;
        stall_plan[15] = 2;
        run_block(1'b0, 1'b0, 1'b0);

        // Ignored START/MSG_VALID outside their phases.
        foreach (stall_plan[k]) stall_plan[k] = 0;
        run_block(1'b1, 1'b1, 1'b0);

        // Chained blocks: second START as early as allowed.
        run_block(1'b1, 1'b0, 1'b0);
        chain_e0 = last_e0;
        run_block(1'b0, 1'b0, 1'b0);
        check_val("chain_done", 32'(last_done - chain_e0), 32'd262);

        // Reset mid-ROUND, then a fresh block from IDLE.
        run_block(1'b1, 1'b0, 1'b1);
        run_block(1'b0, 1'b0, 1'b0);

        // Randomized stalls and noise.
        repeat (4) begin
            foreach (stall_plan[k]) stall_plan[k] = $urandom_range(0, 3);
            run_block(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
